alu_exec_stage: RTL and testbench

- Execute-stage ALU that consumes the 3-bit ALU_Code produced by the ALU control decoder, together with two 16-bit operands.
- Produces a registered result plus status flags.
- Decoupled from fetch/decode and writeback by valid/ready handshakes on both sides.
- Uses a 2-entry skid buffer: full throughput while ready, no combinational ready path from output to input.

---
 rtl/alu_pkg.sv | 38 +++
 rtl/alu_core.sv | 65 ++++++
 rtl/alu_exec_stage.sv | 112 +++++++++++
 tb/tb_alu_exec_stage.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: operation codes, skid-buffer states
// and the packed result record carried through the buffer.
package alu_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int TAG_W_DEF  = 3;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_RSV = 3'b010;
   localparam logic [2:0] ALU_SLT = 3'b011;
   localparam logic [2:0] ALU_AND = 3'b100;
   localparam logic [2:0] ALU_OR  = 3'b101;
   localparam logic [2:0] ALU_NOT = 3'b110;
   localparam logic [2:0] ALU_XOR = 3'b111;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } skid_state_t;

   typedef struct packed {
      logic [DATA_W_DEF-1:0] result;
      logic                  flag_z;
      logic                  flag_n;
      logic                  flag_c;
      logic                  flag_v;
      logic                  illegal;
      logic [TAG_W_DEF-1:0]  tag;
   } alu_res_t;

   // Two's-complement overflow of x + y: same-sign operands, result sign differs.
   function automatic logic add_overflow(input logic x_msb, input logic y_msb, input logic r_msb);
      return (x_msb == y_msb) && (r_msb != x_msb);
   endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: code + operands -> result record with flags.
// Code 010 is a left shift when ALU_EXEC_SHIFT_EN is defined, otherwise a reserved (illegal) code.
module alu_core
   import alu_pkg::*;
(
   input  logic [2:0]            alu_code,
   input  logic [DATA_W_DEF-1:0] op_a,
   input  logic [DATA_W_DEF-1:0] op_b,
   input  logic [TAG_W_DEF-1:0]  in_tag,
   output alu_res_t              res
);

   logic [DATA_W_DEF:0]   sum_ext;
   logic [DATA_W_DEF-1:0] value;
`ifdef ALU_EXEC_SHIFT_EN
   logic [DATA_W_DEF:0]   shl_ext;
`endif

   always_comb begin
      res     = '0;
      value   = '0;
      sum_ext = '0;
`ifdef ALU_EXEC_SHIFT_EN
      shl_ext = '0;
`endif
      case (alu_code)
         ALU_ADD: begin
            sum_ext     = {1'b0, op_a} + {1'b0, op_b};
            value       = sum_ext[DATA_W_DEF-1:0];
            res.flag_c  = sum_ext[DATA_W_DEF];
            res.flag_v  = add_overflow(op_a[DATA_W_DEF-1], op_b[DATA_W_DEF-1],
                                       sum_ext[DATA_W_DEF-1]);
         end
         ALU_SUB: begin
            // a + ~b + 1: a missing carry-out means a borrow (a < b unsigned)
            sum_ext     = {1'b0, op_a} + {1'b0, ~op_b} + {{DATA_W_DEF{1'b0}}, 1'b1};
            value       = sum_ext[DATA_W_DEF-1:0];
            res.flag_c  = ~sum_ext[DATA_W_DEF];
            res.flag_v  = add_overflow(op_a[DATA_W_DEF-1], ~op_b[DATA_W_DEF-1],
                                       sum_ext[DATA_W_DEF-1]);
         end
         ALU_SLT: value = {{(DATA_W_DEF-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         ALU_AND: value = op_a & op_b;
         ALU_OR:  value = op_a | op_b;
         ALU_NOT: value = ~op_a;
         ALU_XOR: value = op_a ^ op_b;
         default: begin
`ifdef ALU_EXEC_SHIFT_EN
            // The extra top bit catches the last bit shifted out.
            shl_ext     = {1'b0, op_a} << op_b[3:0];
            value       = shl_ext[DATA_W_DEF-1:0];
            res.flag_c  = shl_ext[DATA_W_DEF];
`else
            value       = '0;
            res.illegal = 1'b1;
`endif
         end
      endcase
      res.result = value;
      res.flag_z = (value == '0);
      res.flag_n = value[DATA_W_DEF-1];
      res.tag    = in_tag;
   end

endmodule

// File: rtl/alu_exec_stage.sv
// Execute-stage ALU with a 2-entry skid buffer on valid/ready handshakes.
// Optional build macro ALU_EXEC_SHIFT_EN turns code 010 into a logical shift left.
module alu_exec_stage
   import alu_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int TAG_W  = TAG_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        alu_code,
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
   input  logic [TAG_W-1:0]  in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] result,
   output logic [TAG_W-1:0]  out_tag,
   output logic              flag_z,
   output logic              flag_n,
   output logic              flag_c,
   output logic              flag_v,
   output logic              illegal_op,
   output logic              err_sticky
);

   skid_state_t state_reg;
   skid_state_t state_next;
   alu_res_t    core_res;
   alu_res_t    out_reg;
   alu_res_t    skid_reg;
   logic        err_sticky_reg;
   logic        accept;
   logic        drain;

   alu_core u_core (
      .alu_code (alu_code),
      .op_a     (op_a),
      .op_b     (op_b),
      .in_tag   (in_tag),
      .res      (core_res)
   );

   assign accept = in_valid & in_ready;
   assign drain  = out_valid & out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_EMPTY;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_EMPTY: if (accept) state_next = ST_ONE;
         ST_ONE: begin
            if (drain && !accept)      state_next = ST_EMPTY;
            else if (accept && !drain) state_next = ST_TWO;
         end
         ST_TWO:   if (drain) state_next = ST_ONE;
         default:  state_next = ST_EMPTY;
      endcase
   end

   // in_ready and out_valid come straight from the state register, never from out_ready.
   always_comb begin
      in_ready  = 1'b1;
      out_valid = 1'b0;
      case (state_reg)
         ST_ONE: out_valid = 1'b1;
         ST_TWO: begin
            out_valid = 1'b1;
            in_ready  = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_reg        <= '0;
         skid_reg       <= '0;
         err_sticky_reg <= 1'b0;
      end else begin
         case (state_reg)
            ST_EMPTY: if (accept) out_reg <= core_res;
            ST_ONE: begin
               if (accept && drain) out_reg  <= core_res;
               else if (accept)     skid_reg <= core_res;
            end
            ST_TWO:   if (drain) out_reg <= skid_reg;
            default: ;
         endcase
         if (accept && core_res.illegal) err_sticky_reg <= 1'b1;
      end
   end

   assign result     = out_reg.result;
   assign out_tag    = out_reg.tag;
   assign flag_z     = out_reg.flag_z;
   assign flag_n     = out_reg.flag_n;
   assign flag_c     = out_reg.flag_c;
   assign flag_v     = out_reg.flag_v;
   assign illegal_op = out_reg.illegal;
   assign err_sticky = err_sticky_reg;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: directed scenarios plus randomized traffic
// checked against an arithmetic reference model and a FIFO scoreboard.
module tb_alu_exec_stage;

`ifdef ALU_EXEC_SHIFT_EN
   localparam bit SHIFT = 1'b1;
`else
   localparam bit SHIFT = 1'b0;
`endif

   typedef struct packed {
      logic [15:0] r;
      logic        z;
      logic        n;
      logic        c;
      logic        v;
      logic        ill;
      logic [2:0]  tag;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  alu_code;
   logic [15:0] op_a;
   logic [15:0] op_b;
   logic [2:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] result;
   logic [2:0]  out_tag;
   logic        flag_z, flag_n, flag_c, flag_v, illegal_op, err_sticky;

   int errors = 0;
   int checks = 0;
   bit exp_sticky = 1'b0;

   wire [23:0] got = {result, flag_z, flag_n, flag_c, flag_v, illegal_op, out_tag};

   alu_exec_stage dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .alu_code   (alu_code),
      .op_a       (op_a),
      .op_b       (op_b),
      .in_tag     (in_tag),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .result     (result),
      .out_tag    (out_tag),
      .flag_z     (flag_z),
      .flag_n     (flag_n),
      .flag_c     (flag_c),
      .flag_v     (flag_v),
      .illegal_op (illegal_op),
      .err_sticky (err_sticky)
   );

   always #5 clk = ~clk;

   // Reference model: plain integer arithmetic on the stated rules.
   function automatic exp_t model(input logic [2:0] code, input logic [15:0] a,
                                  input logic [15:0] b, input logic [2:0] tag);
      exp_t e;
      int ia, ib, sa, sb, s, sh;
      e  = '0;
      ia = int'(a);
      ib = int'(b);
      sa = int'($signed(a));
      sb = int'($signed(b));
      case (code)
         3'd0: begin
            s   = ia + ib;
            e.r = s[15:0];
            e.c = (s > 65535);
            e.v = ((sa + sb) > 32767) || ((sa + sb) < -32768);
         end
         3'd1: begin
            s   = ia - ib;
            e.r = s[15:0];
            e.c = (ia < ib);
            e.v = ((sa - sb) > 32767) || ((sa - sb) < -32768);
         end
         3'd2: begin
            if (SHIFT) begin
               sh  = int'(b[3:0]);
               s   = ia * (1 << sh);
               e.r = s[15:0];
               e.c = (sh == 0) ? 1'b0 : a[16 - sh];
            end else begin
               e.ill = 1'b1;
            end
         end
         3'd3: e.r = (sa < sb) ? 16'd1 : 16'd0;
         3'd4: e.r = a & b;
         3'd5: e.r = a | b;
         3'd6: e.r = ~a;
         default: e.r = a ^ b;
      endcase
      e.z   = (e.r == 16'd0);
      e.n   = e.r[15];
      e.tag = tag;
      return e;
   endfunction

   // Drives one op with out_ready=1 into an empty stage; lat = extra cycles beyond 1.
   task automatic send(input logic [2:0] code, input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] tag, output int lat);
      @(negedge clk);
      alu_code  = code;
      op_a      = a;
      op_b      = b;
      in_tag    = tag;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      if (code == 3'd2 && !SHIFT) exp_sticky = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 8) begin
         @(negedge clk);
         lat++;
      end
      if (!out_valid) begin
         errors++;
         $display("FAIL send_timeout: out_valid=%0b required=1", out_valid);
      end
   endtask

   task automatic drain_idle();
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      alu_code = '0; op_a = '0; op_b = '0; in_tag = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready, err_sticky} !== 3'b010) begin
         errors++;
         $display("FAIL reset_handshake: got v/r/err=%b required 010", {out_valid, in_ready, err_sticky});
      end
      checks++;
      if (got !== 24'd0) begin
         errors++;
         $display("FAIL reset_fields: got %h required 000000", got);
      end
   endtask

   task automatic test_add();
      exp_t e;
      int lat;
      logic [15:0] a, b;
      send(3'd0, 16'h7FFF, 16'h0001, 3'd5, lat);
      e = model(3'd0, 16'h7FFF, 16'h0001, 3'd5);
      checks++;
      if (got !== e || lat != 0) begin
         errors++;
         $display("FAIL add_overflow: got %h lat=%0d required %h lat=0", got, lat, e);
      end
      for (int i = 0; i < 4; i++) begin
         a = 16'($urandom); b = 16'($urandom);
         send(3'd0, a, b, 3'(i), lat);
         e = model(3'd0, a, b, 3'(i));
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL add_rand a=%h b=%h: got %h required %h", a, b, got, e);
         end
      end
   endtask

   task automatic test_sub();
      exp_t e;
      int lat;
      send(3'd1, 16'h0005, 16'h0007, 3'd1, lat);
      e = model(3'd1, 16'h0005, 16'h0007, 3'd1);
      checks++;
      if (got !== e || result !== 16'hFFFE) begin
         errors++;
         $display("FAIL sub_borrow: got %h required %h", got, e);
      end
      send(3'd1, 16'h1234, 16'h1234, 3'd2, lat);
      e = model(3'd1, 16'h1234, 16'h1234, 3'd2);
      checks++;
      if (got !== e) begin
         errors++;
         $display("FAIL sub_zero: got %h required %h", got, e);
      end
      send(3'd1, 16'h8000, 16'h0001, 3'd3, lat);
      e = model(3'd1, 16'h8000, 16'h0001, 3'd3);
      checks++;
      if (got !== e) begin
         errors++;
         $display("FAIL sub_overflow: got %h required %h", got, e);
      end
   endtask

   task automatic test_slt();
      exp_t e;
      int lat;
      send(3'd3, 16'hFFFF, 16'h0001, 3'd4, lat);
      e = model(3'd3, 16'hFFFF, 16'h0001, 3'd4);
      checks++;
      if (got !== e || result !== 16'd1) begin
         errors++;
         $display("FAIL slt_neg: got %h required %h", got, e);
      end
      send(3'd3, 16'h0001, 16'hFFFF, 3'd6, lat);
      e = model(3'd3, 16'h0001, 16'hFFFF, 3'd6);
      checks++;
      if (got !== e) begin
         errors++;
         $display("FAIL slt_pos: got %h required %h", got, e);
      end
   endtask

   task automatic test_logic();
      exp_t e;
      int lat;
      logic [15:0] a, b;
      for (int c = 4; c < 8; c++) begin
         a = 16'($urandom); b = 16'($urandom);
         send(3'(c), a, b, 3'(c), lat);
         e = model(3'(c), a, b, 3'(c));
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL logic code=%0d a=%h b=%h: got %h required %h", c, a, b, got, e);
         end
      end
   endtask

   task automatic test_backpressure();
      exp_t q[3];
      logic [15:0] a[3], b[3];
      logic [2:0]  cd[3];
      int k;
      bit xfer;
      drain_idle();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         a[i] = 16'($urandom); b[i] = 16'($urandom);
         cd[i] = (i == 1) ? 3'd1 : 3'd0;
         q[i] = model(cd[i], a[i], b[i], 3'(i + 1));
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (in_ready !== (i < 2)) begin
            errors++;
            $display("FAIL bp_in_ready op%0d: got %b required %b", i + 1, in_ready, (i < 2));
         end
         alu_code = cd[i]; op_a = a[i]; op_b = b[i]; in_tag = 3'(i + 1); in_valid = 1'b1;
      end
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (got !== q[0] || in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_stall: got %h rdy=%b required %h rdy=0", got, in_ready, q[0]);
         end
      end
      out_ready = 1'b1;
      k = 0;
      for (int cyc = 0; cyc < 10 && k < 3; cyc++) begin
         if (out_valid) begin
            checks++;
            if (got !== q[k]) begin
               errors++;
               $display("FAIL bp_order idx=%0d: got %h required %h", k, got, q[k]);
            end
            k++;
         end
         xfer = in_valid && in_ready;
         @(posedge clk);
         #1;
         if (xfer) in_valid = 1'b0;
         @(negedge clk);
      end
      checks++;
      if (k != 3 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_count: got %0d outputs valid=%b required 3 outputs valid=0", k, out_valid);
      end
   endtask

   task automatic test_reserved();
      exp_t e;
      int lat;
      send(3'd2, 16'h8001, 16'h0001, 3'd7, lat);
      e = model(3'd2, 16'h8001, 16'h0001, 3'd7);
      checks++;
      if (got !== e) begin
         errors++;
         $display("FAIL code010: got %h required %h", got, e);
      end
      checks++;
      if (err_sticky !== exp_sticky) begin
         errors++;
         $display("FAIL sticky_set: got %b required %b", err_sticky, exp_sticky);
      end
      send(3'd0, 16'h0001, 16'h0002, 3'd1, lat);
      checks++;
      if (err_sticky !== exp_sticky || illegal_op !== 1'b0) begin
         errors++;
         $display("FAIL sticky_hold: got err=%b ill=%b required err=%b ill=0", err_sticky, illegal_op, exp_sticky);
      end
   endtask

   task automatic test_random();
      exp_t sb[$];
      exp_t e;
      logic [23:0] prev_got;
      bit prev_stall, acc, drn;
      drain_idle();
      prev_stall = 1'b0;
      prev_got = '0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(negedge clk);
         if (prev_stall) begin
            checks++;
            if (got !== prev_got) begin
               errors++;
               $display("FAIL rand_stable cyc=%0d: got %h required %h", cyc, got, prev_got);
            end
         end
         checks++;
         if (in_ready !== (sb.size() < 2) || out_valid !== (sb.size() > 0)) begin
            errors++;
            $display("FAIL rand_occupancy cyc=%0d: got rdy=%b vld=%b required occupancy %0d",
                     cyc, in_ready, out_valid, sb.size());
         end
         if (!in_valid && ($urandom_range(0, 9) < 7)) begin
            alu_code = 3'($urandom); op_a = 16'($urandom); op_b = 16'($urandom);
            in_tag = 3'($urandom); in_valid = 1'b1;
         end
         out_ready = ($urandom_range(0, 9) < 6);
         acc = in_valid && in_ready;
         drn = out_valid && out_ready;
         if (drn) begin
            e = sb.pop_front();
            checks++;
            if (got !== e) begin
               errors++;
               $display("FAIL rand_data cyc=%0d: got %h required %h", cyc, got, e);
            end
         end
         if (acc) begin
            sb.push_back(model(alu_code, op_a, op_b, in_tag));
            if (alu_code == 3'd2 && !SHIFT) exp_sticky = 1'b1;
         end
         prev_stall = out_valid && !out_ready;
         prev_got   = got;
         @(posedge clk);
         #1;
         if (acc) in_valid = 1'b0;
      end
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 10 && sb.size() > 0; cyc++) begin
         @(negedge clk);
         if (out_valid) begin
            e = sb.pop_front();
            checks++;
            if (got !== e) begin
               errors++;
               $display("FAIL rand_flush: got %h required %h", got, e);
            end
         end
      end
      checks++;
      if (sb.size() != 0 || err_sticky !== exp_sticky) begin
         errors++;
         $display("FAIL rand_end: got left=%0d err=%b required left=0 err=%b", sb.size(), err_sticky, exp_sticky);
      end
   endtask

   task automatic test_reset_mid_stall();
      exp_t e;
      int lat;
      drain_idle();
      out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         alu_code = 3'd0; op_a = 16'($urandom); op_b = 16'($urandom);
         in_tag = 3'(i); in_valid = 1'b1;
      end
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL mid_two: got rdy=%b vld=%b required rdy=0 vld=1", in_ready, out_valid);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({out_valid, in_ready, err_sticky} !== 3'b010 || got !== 24'd0) begin
         errors++;
         $display("FAIL mid_reset: got v/r/err=%b fields=%h required 010 000000",
                  {out_valid, in_ready, err_sticky}, got);
      end
      exp_sticky = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      send(3'd1, 16'h0100, 16'h0001, 3'd3, lat);
      e = model(3'd1, 16'h0100, 16'h0001, 3'd3);
      checks++;
      if (got !== e || lat != 0) begin
         errors++;
         $display("FAIL post_reset_op: got %h lat=%0d required %h lat=0", got, lat, e);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_alone: got out_valid=%b required 0", out_valid);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_slt();
      test_logic();
      test_backpressure();
      test_reserved();
      test_random();
      test_reset_mid_stall();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
